// File: rtl/pio_edge_servicer.sv
// pio_edge_servicer
//   Autonomous Avalon-MM master for a single input PIO. After reset it writes
//   the PIO irq_mask once. After that it services edge_capture whenever the
//   PIO interrupts or a poll timer expires: read edges, read the live level,
//   clear the edges, and queue non-zero {level, edges} snapshots in a small
//   first-word-fall-through event FIFO.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   pio_address/chipselect/write_n/writedata   registered bus master outputs
//   pio_readdata        PIO read data, valid one cycle after the address
//   pio_irq             PIO level interrupt (sampled only while idle)
//   evt_valid/evt_data  FIFO head {level, edges}; popped on evt_ready
//   overflow/drop_count sticky drop flag and saturating drop counter
//   clr_overflow        clears overflow and drop_count (wins over a drop)
module pio_edge_servicer #(
    parameter int          DATA_WIDTH  = 10,
    parameter int          FIFO_DEPTH  = 4,
    parameter int          POLL_PERIOD = 1000,
    parameter logic [31:0] MASK_INIT   = 32'h3FF
) (
    input  logic                    clk,
    input  logic                    reset_n,
    output logic [1:0]              pio_address,
    output logic                    pio_chipselect,
    output logic                    pio_write_n,
    output logic [31:0]             pio_writedata,
    input  logic [31:0]             pio_readdata,
    input  logic                    pio_irq,
    output logic                    evt_valid,
    output logic [2*DATA_WIDTH-1:0] evt_data,
    input  logic                    evt_ready,
    output logic                    overflow,
    output logic [7:0]              drop_count,
    input  logic                    clr_overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int TW = $clog2(POLL_PERIOD);
    localparam int EW = 2 * DATA_WIDTH;
    // Mask value trimmed to the port width, then zero-extended to the bus.
    localparam logic [31:0] MASK_W = MASK_INIT & ((32'd1 << DATA_WIDTH) - 32'd1);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_RD_EDGE, S_RD_LEVEL, S_CLR, S_PUSH
    } state_t;

    state_t              state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic                cs_q, cs_d, we_n_q, we_n_d;
    logic [1:0]          addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] edges_q, edges_d, level_q, level_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                evt_valid_q, evt_valid_d;
    logic [EW-1:0]       evt_data_q, evt_data_d;
    logic                ovf_q, ovf_d;
    logic [7:0]          drop_q, drop_d;
    logic [EW-1:0]       mem_q [FIFO_DEPTH];

    logic                trigger, pop, want_push, push, drop, full;
    logic [PW-1:0]       count_q, count_d;
    logic [EW-1:0]       push_data;
    logic                unused_readdata;

    assign unused_readdata = ^pio_readdata;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + TW'(1);
        cs_d    = 1'b0;
        we_n_d  = 1'b1;
        addr_d  = 2'd0;
        wdata_d = 32'd0;
        edges_d = edges_q;
        level_d = level_q;
        trigger = (state_q == S_IDLE) && (pio_irq || (timer_q == TW'(POLL_PERIOD - 1)));

        // Bus registers are loaded with the access belonging to the state
        // being entered, so the address is on the bus during that state and
        // its read data lands during the following one.
        case (state_q)
            S_INIT: begin
                state_d = S_IDLE;
                cs_d    = 1'b1;
                we_n_d  = 1'b0;
                addr_d  = 2'd2;
                wdata_d = MASK_W;
            end
            S_IDLE: begin
                if (trigger) begin
                    state_d = S_RD_EDGE;
                    timer_d = '0;
                    cs_d    = 1'b1;
                    addr_d  = 2'd3;
                end
            end
            S_RD_EDGE: begin
                state_d = S_RD_LEVEL;
                cs_d    = 1'b1;
                addr_d  = 2'd0;
            end
            S_RD_LEVEL: begin
                edges_d = pio_readdata[DATA_WIDTH-1:0];
                state_d = S_CLR;
                cs_d    = 1'b1;
                we_n_d  = 1'b0;
                addr_d  = 2'd3;
                wdata_d = '1;
            end
            S_CLR: begin
                level_d = pio_readdata[DATA_WIDTH-1:0];
                state_d = S_PUSH;
            end
            S_PUSH: begin
                state_d = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase
    end

    // Event FIFO: pop is resolved before push so a full FIFO being drained
    // in the PUSH cycle still accepts the new entry.
    always_comb begin
        count_q   = wr_ptr_q - rd_ptr_q;
        full      = (count_q == PW'(FIFO_DEPTH));
        pop       = evt_valid_q && evt_ready;
        want_push = (state_q == S_PUSH) && (edges_q != '0);
        push      = want_push && (!full || pop);
        drop      = want_push && full && !pop;
        push_data = {level_q, edges_q};
        wr_ptr_d  = wr_ptr_q + PW'(push);
        rd_ptr_d  = rd_ptr_q + PW'(pop);
        count_d   = wr_ptr_d - rd_ptr_d;
        evt_valid_d = (count_d != '0);
        evt_data_d  = '0;
        if (count_d != '0) begin
            // New head is the slot being written only when it becomes the sole entry.
            if (push && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0]))
                evt_data_d = push_data;
            else
                evt_data_d = mem_q[rd_ptr_d[AW-1:0]];
        end

        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (clr_overflow) begin
            ovf_d  = 1'b0;
            drop_d = 8'd0;
        end else if (drop) begin
            ovf_d  = 1'b1;
            drop_d = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_INIT;
            timer_q     <= '0;
            cs_q        <= 1'b0;
            we_n_q      <= 1'b1;
            addr_q      <= 2'd0;
            wdata_q     <= 32'd0;
            edges_q     <= '0;
            level_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            evt_valid_q <= 1'b0;
            evt_data_q  <= '0;
            ovf_q       <= 1'b0;
            drop_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            cs_q        <= cs_d;
            we_n_q      <= we_n_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            edges_q     <= edges_d;
            level_q     <= level_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            evt_valid_q <= evt_valid_d;
            evt_data_q  <= evt_data_d;
            ovf_q       <= ovf_d;
            drop_q      <= drop_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

    assign pio_chipselect = cs_q;
    assign pio_write_n    = we_n_q;
    assign pio_address    = addr_q;
    assign pio_writedata  = wdata_q;
    assign evt_valid      = evt_valid_q;
    assign evt_data       = evt_data_q;
    assign overflow       = ovf_q;
    assign drop_count     = drop_q;

endmodule

// File: tb/tb_pio_edge_servicer.sv
// Bench for pio_edge_servicer: a small PIO slave model, a transaction-level
// reference model (pass schedule + event queue), a per-cycle compare process
// and directed scenarios with hand-computed expectations.
module tb_pio_edge_servicer;

    localparam int P     = 1000;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  pio_address;
    logic        pio_chipselect, pio_write_n;
    logic [31:0] pio_writedata;
    logic [31:0] pio_readdata = 32'd0;
    logic        pio_irq = 1'b0;
    logic        evt_valid;
    logic [19:0] evt_data;
    logic        evt_ready = 1'b0;
    logic        overflow;
    logic [7:0]  drop_count;
    logic        clr_overflow = 1'b0;

    pio_edge_servicer #(.DATA_WIDTH(10), .FIFO_DEPTH(DEPTH), .POLL_PERIOD(P),
                        .MASK_INIT(32'h3FF)) dut (
        .clk(clk), .reset_n(reset_n),
        .pio_address(pio_address), .pio_chipselect(pio_chipselect),
        .pio_write_n(pio_write_n), .pio_writedata(pio_writedata),
        .pio_readdata(pio_readdata), .pio_irq(pio_irq),
        .evt_valid(evt_valid), .evt_data(evt_data), .evt_ready(evt_ready),
        .overflow(overflow), .drop_count(drop_count), .clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;

    // ---------------- PIO slave model ----------------
    logic [9:0]  data_in  = 10'd0;
    logic [9:0]  edge_set = 10'd0;
    logic [9:0]  edge_cap = 10'd0;
    logic [31:0] mask_reg = 32'd0;

    always @(posedge clk) begin
        if (pio_chipselect && pio_write_n) begin
            case (pio_address)
                2'd0:    pio_readdata <= {22'd0, data_in};
                2'd2:    pio_readdata <= mask_reg;
                2'd3:    pio_readdata <= {22'd0, edge_cap};
                default: pio_readdata <= 32'd0;
            endcase
        end
        if (pio_chipselect && !pio_write_n && pio_address == 2'd2) mask_reg <= pio_writedata;
        if (pio_chipselect && !pio_write_n && pio_address == 2'd3)
            edge_cap <= (edge_cap & ~pio_writedata[9:0]) | edge_set;
        else
            edge_cap <= edge_cap | edge_set;
    end

    // ---------------- reference model ----------------
    int          cyc = 0;          // cycles since reset release (cycle 0 = INIT)
    int          last_trig = -1;
    int          t_pass = -100;
    int          idle_from = 1;
    logic [9:0]  m_edges = 10'd0, m_level = 10'd0;
    logic [19:0] q[$];
    logic        m_ovf = 1'b0;
    int          m_cnt = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc = 0; last_trig = -1; t_pass = -100; idle_from = 1;
            q.delete(); m_ovf = 1'b0; m_cnt = 0;
        end else begin
            bit trig, drp;
            drp = 1'b0;
            trig = (cyc >= idle_from) && (pio_irq || (cyc - last_trig) == P);
            if (cyc == t_pass + 1) m_edges = edge_cap;
            if (cyc == t_pass + 2) m_level = data_in;
            if (q.size() > 0 && evt_ready) void'(q.pop_front());
            if (cyc == t_pass + 4 && m_edges != 10'd0) begin
                if (q.size() < DEPTH) q.push_back({m_level, m_edges});
                else drp = 1'b1;
            end
            if (clr_overflow) begin
                m_ovf = 1'b0; m_cnt = 0;
            end else if (drp) begin
                m_ovf = 1'b1; if (m_cnt < 255) m_cnt++;
            end
            if (trig) begin
                last_trig = cyc; t_pass = cyc; idle_from = cyc + 5;
            end
            cyc++;
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0, n_pass = 0;
    int rd3_count = 0, last_rd3 = 0, prev_rd3 = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_cs", 32'(pio_chipselect), 32'd0);
            chk("rst_we_n", 32'(pio_write_n), 32'd1);
            chk("rst_evt_valid", 32'(evt_valid), 32'd0);
            chk("rst_overflow", 32'(overflow), 32'd0);
            chk("rst_drop_count", 32'(drop_count), 32'd0);
        end else begin
            logic e_cs, e_wn;
            logic [1:0] e_a;
            logic [31:0] e_wd;
            e_cs = 1'b0; e_wn = 1'b1; e_a = 2'd0; e_wd = 32'd0;
            if (cyc == 1)               begin e_cs = 1'b1; e_wn = 1'b0; e_a = 2'd2; e_wd = 32'h3FF; end
            else if (cyc == t_pass + 1) begin e_cs = 1'b1; e_a = 2'd3; end
            else if (cyc == t_pass + 2) begin e_cs = 1'b1; e_a = 2'd0; end
            else if (cyc == t_pass + 3) begin e_cs = 1'b1; e_wn = 1'b0; e_a = 2'd3; e_wd = 32'hFFFF_FFFF; end
            chk("bus_cs", 32'(pio_chipselect), 32'(e_cs));
            chk("bus_we_n", 32'(pio_write_n), 32'(e_wn));
            if (e_cs) begin
                chk("bus_addr", 32'(pio_address), 32'(e_a));
                if (!e_wn) chk("bus_wdata", pio_writedata, e_wd);
            end
            chk("evt_valid", 32'(evt_valid), 32'(q.size() > 0));
            chk("evt_data", 32'(evt_data), (q.size() > 0) ? 32'(q[0]) : 32'd0);
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("drop_count", 32'(drop_count), 32'(m_cnt));
            if (pio_chipselect && pio_write_n && pio_address == 2'd3) begin
                prev_rd3 = last_rd3; last_rd3 = cyc; rd3_count++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic fire(input logic [9:0] e, input logic [9:0] lv, output int t);
        @(negedge clk); data_in = lv; edge_set = e;
        @(negedge clk); edge_set = 10'd0; pio_irq = 1'b1; t = cyc;
        @(negedge clk); pio_irq = 1'b0;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_rd3();
        int start, k;
        start = rd3_count; k = 0;
        while (rd3_count == start && k < 1100) begin @(negedge clk); k++; end
        n_checks++;
        if (rd3_count != start) n_pass++;
        else $display("FAIL poll_wait: no service pass in %0d cycles, expected one", k);
    endtask

    task automatic pop_one();
        evt_ready = 1'b1; @(negedge clk); evt_ready = 1'b0;
    endtask

    initial begin
        int t;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        chk("init_cs", 32'(pio_chipselect), 32'd1);
        chk("init_we_n", 32'(pio_write_n), 32'd0);
        chk("init_addr", 32'(pio_address), 32'd2);
        chk("init_wdata", pio_writedata, 32'h3FF);
        repeat (20) @(negedge clk);

        // irq-driven pass
        fire(10'h005, 10'h3F0, t);
        wait_cyc(t + 3);
        chk("irq_clr_write", {29'd0, pio_chipselect, pio_write_n, pio_address[0]}, 32'b101);
        wait_cyc(t + 5);
        chk("irq_evt_valid", 32'(evt_valid), 32'd1);
        chk("irq_evt_data", 32'(evt_data), 32'({10'h3F0, 10'h005}));
        pop_one();

        // periodic poll with an edge
        @(negedge clk); data_in = 10'h155; edge_set = 10'h200;
        @(negedge clk); edge_set = 10'd0;
        wait_rd3();
        chk("poll_period", 32'(last_rd3 - prev_rd3), 32'd1000);
        wait_cyc(last_rd3 + 4);
        chk("poll_evt_data", 32'(evt_data), 32'({10'h155, 10'h200}));
        pop_one();

        // poll with no edges: full sequence, nothing queued
        wait_rd3();
        chk("poll0_period", 32'(last_rd3 - prev_rd3), 32'd1000);
        wait_cyc(last_rd3 + 6);
        chk("poll0_no_evt", 32'(evt_valid), 32'd0);

        // overflow: six events into a four-deep FIFO
        for (int i = 0; i < 6; i++) begin
            fire(10'(1 << i), 10'(32'h100 + i), t);
            wait_cyc(t + 6);
        end
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(drop_count), 32'd2);
        clr_overflow = 1'b1; @(negedge clk); clr_overflow = 1'b0;
        chk("clr_flag", 32'(overflow), 32'd0);
        chk("clr_count", 32'(drop_count), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("drain_order", 32'(evt_data), 32'({10'(32'h100 + i), 10'(1 << i)}));
            pop_one();
        end
        chk("drain_empty", 32'(evt_valid), 32'd0);

        // full FIFO, consumer pops in the PUSH cycle: no drop
        for (int i = 0; i < 4; i++) begin
            fire(10'h003, 10'(32'h10 + i), t);
            wait_cyc(t + 6);
        end
        fire(10'h0C0, 10'h2AA, t);
        wait_cyc(t + 4);
        pop_one();
        chk("full_pop_no_ovf", 32'(overflow), 32'd0);
        chk("full_pop_head", 32'(evt_data), 32'({10'h011, 10'h003}));
        chk("full_pop_valid", 32'(evt_valid), 32'd1);

        // reset in the middle of a pass
        fire(10'h011, 10'h0AB, t);
        wait_cyc(t + 2);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_evt_valid", 32'(evt_valid), 32'd0);
        chk("midrst_cs", 32'(pio_chipselect), 32'd0);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        chk("reinit_cs", 32'(pio_chipselect), 32'd1);
        chk("reinit_addr", 32'(pio_address), 32'd2);
        chk("reinit_wdata", pio_writedata, 32'h3FF);
        repeat (10) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
